// File: rtl/mux_debouncer_pkg.sv
// Shared constants and helpers for the multi-line multiplexed debouncer.
// Channel numbering is line-major: channel = line * 2^addr_bits + addr.
package mux_debouncer_pkg;

    localparam int DEF_CLK_DIV_BITS          = 5;
    localparam int DEF_MUX_ADDR_BITS         = 4;
    localparam int DEF_MUX_LINES             = 2;
    localparam int DEF_DEBOUNCE_COUNTER_BITS = 12;
    localparam int DEF_SAMPLE_POINT          = 2;

    // Total debounced channels served by one scan engine.
    function automatic int num_channels(input int lines, input int addr_bits);
        return lines << addr_bits;
    endfunction

    function automatic int chan_index(input int line, input int addr,
                                      input int addr_bits = DEF_MUX_ADDR_BITS);
        return (line << addr_bits) + addr;
    endfunction

    // The sample point must leave at least one cycle between sampling and the
    // slot-end update, and must not coincide with it.
    function automatic bit sample_point_ok(input int sample_point, input int div_bits);
        return (sample_point >= 1) && (sample_point <= (1 << div_bits) - 1);
    endfunction

endpackage

// File: rtl/debounce_line_bank.sv
// Per-line debounce state: counter RAM, valid bits and next-state logic for the
// channels behind one external MUX.
module debounce_line_bank
    import mux_debouncer_pkg::*;
#(
    parameter int ADDR_BITS    = DEF_MUX_ADDR_BITS,
    parameter int COUNTER_BITS = DEF_DEBOUNCE_COUNTER_BITS
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic                    update_en,
    input  logic                    sample,
    input  logic                    debounced,
    input  logic [COUNTER_BITS-1:0] limit,
    output logic                    flip
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [COUNTER_BITS-1:0] cnt_ram [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic [COUNTER_BITS-1:0] cnt_cur;
    logic [COUNTER_BITS-1:0] cnt_next;

    // A never-written entry reads as zero, so stale RAM contents are harmless.
    assign cnt_cur = valid[addr] ? cnt_ram[addr] : '0;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path infers a latch.
        flip     = 1'b0;
        cnt_next = '0;
        if (update_en && (sample != debounced)) begin
            if (cnt_cur >= limit) begin
                flip = 1'b1;
            end else begin
                cnt_next = cnt_cur + COUNTER_BITS'(1);
            end
        end
    end

    // NOTE: the counter RAM is deliberately left without reset so it maps onto
    // distributed RAM; the valid bits below carry the reset meaning instead.
    always_ff @(posedge CLK) begin
        if (update_en) begin
            cnt_ram[addr] <= cnt_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid <= '0;
        end else if (update_en) begin
            valid[addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/mux_debouncer_multi.sv
// Multi-line multiplexed debouncer: one shared MUX address scans MUX_LINES
// external multiplexers, with programmable threshold and sticky change flags.
module mux_debouncer_multi
    import mux_debouncer_pkg::*;
#(
    parameter int CLK_DIV_BITS          = DEF_CLK_DIV_BITS,
    parameter int MUX_ADDR_BITS         = DEF_MUX_ADDR_BITS,
    parameter int MUX_LINES             = DEF_MUX_LINES,
    parameter int DEBOUNCE_COUNTER_BITS = DEF_DEBOUNCE_COUNTER_BITS,
    parameter int SAMPLE_POINT          = DEF_SAMPLE_POINT
) (
    input  logic                                             CLK,
    input  logic                                             RESET_N,
    output logic [MUX_ADDR_BITS-1:0]                         MUX_ADDR,
    input  logic [MUX_LINES-1:0]                             MUX_OUT,
    input  logic [DEBOUNCE_COUNTER_BITS-1:0]                 DEBOUNCE_LIMIT,
    output logic [num_channels(MUX_LINES, MUX_ADDR_BITS)-1:0] DEBOUNCED,
    output logic [num_channels(MUX_LINES, MUX_ADDR_BITS)-1:0] CHANGE_FLAGS,
    input  logic [num_channels(MUX_LINES, MUX_ADDR_BITS)-1:0] CLEAR_FLAGS,
    output logic                                             CHANGED,
    output logic                                             SCAN_DONE
);

    localparam int N     = num_channels(MUX_LINES, MUX_ADDR_BITS);
    localparam int DEPTH = 1 << MUX_ADDR_BITS;

    if (!sample_point_ok(SAMPLE_POINT, CLK_DIV_BITS)) begin : g_bad_sample_point
        $error("SAMPLE_POINT must lie in 1 .. 2**CLK_DIV_BITS-1");
    end

    logic [CLK_DIV_BITS-1:0] clk_div;
    logic [MUX_LINES-1:0]    sample_reg;
    logic [MUX_LINES-1:0]    flip;
    logic [N-1:0]            set_flags;
    logic                    slot_end;
    logic                    sample_now;

    assign slot_end   = (clk_div == '0);
    assign sample_now = (clk_div == CLK_DIV_BITS'(SAMPLE_POINT));

    // Down-counting divider; the address moves on the same edge as the update
    // of the slot it leaves, so the next slot starts with a fresh address.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_div    <= '1;
            MUX_ADDR   <= '1;
            sample_reg <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees the pre-edge clk_div.
            clk_div <= clk_div - CLK_DIV_BITS'(1);
            if (slot_end) begin
                MUX_ADDR <= MUX_ADDR - MUX_ADDR_BITS'(1);
            end
            if (sample_now) begin
                sample_reg <= MUX_OUT;
            end
        end
    end

    for (genvar l = 0; l < MUX_LINES; l++) begin : g_line
        localparam int BASE = chan_index(l, 0, MUX_ADDR_BITS);

        logic [DEPTH-1:0] line_db;

        assign line_db = DEBOUNCED[BASE +: DEPTH];

        debounce_line_bank #(
            .ADDR_BITS    (MUX_ADDR_BITS),
            .COUNTER_BITS (DEBOUNCE_COUNTER_BITS)
        ) u_bank (
            .CLK       (CLK),
            .RESET_N   (RESET_N),
            .addr      (MUX_ADDR),
            .update_en (slot_end),
            .sample    (sample_reg[l]),
            .debounced (line_db[MUX_ADDR]),
            .limit     (DEBOUNCE_LIMIT),
            .flip      (flip[l])
        );

        assign set_flags[BASE +: DEPTH] = flip[l] ? (DEPTH'(1) << MUX_ADDR) : '0;
    end

    // A set in the same cycle as a clear wins, so a flip is never lost.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DEBOUNCED    <= '0;
            CHANGE_FLAGS <= '0;
            SCAN_DONE    <= 1'b0;
        end else begin
            DEBOUNCED    <= DEBOUNCED ^ set_flags;
            CHANGE_FLAGS <= (CHANGE_FLAGS & ~CLEAR_FLAGS) | set_flags;
            SCAN_DONE    <= slot_end && (MUX_ADDR == '0);
        end
    end

    assign CHANGED = |CHANGE_FLAGS;

endmodule
